// File: rtl/ad_data_gen_pkg.sv
// ad_data_gen_pkg: shared encodings and constants for the ADC stand-in
// Holds mode and FSM encodings, the default mid-scale code and the dither LFSR constants.
package ad_data_gen_pkg;
  typedef enum logic [1:0] {
    MODE_MID  = 2'b00,
    MODE_RAMP = 2'b01,
    MODE_TRI  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;
  localparam logic [7:0]  DEF_MID_CODE = 8'd125;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;
  // feedback taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
endpackage

// File: rtl/ad_data_gen_lfsr.sv
// ad_data_gen_lfsr: 16-bit Fibonacci LFSR supplying a 2-bit dither select
// Ports: clk_four sample clock, sys_rst_n async active-low reset (loads the seed),
//   dither = lfsr[1:0]. Only present when AD_DATA_GEN_NOISE_EN is defined.
`ifdef AD_DATA_GEN_NOISE_EN
module ad_data_gen_lfsr
  import ad_data_gen_pkg::*;
(
  input  logic       clk_four,
  input  logic       sys_rst_n,
  output logic [1:0] dither
);
  logic [15:0] lfsr;
  always_ff @(posedge clk_four or negedge sys_rst_n)
    if (!sys_rst_n) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  assign dither = lfsr[1:0];
endmodule
`endif

// File: rtl/ad_data_gen.sv
// ad_data_gen: ADC stand-in that holds mid-scale while settling, then emits test waveforms
// Ports: clk_four sample clock; sys_rst_n async active-low reset; start run enable (level);
//   mode 00 mid / 01 ramp / 10 triangle / 11 hold; hold_code constant for hold mode;
//   ad_data core code delayed PIPE_LAT cycles; settle_done high while running (not delayed).
// Optional: define AD_DATA_GEN_NOISE_EN to add +/-1 LFSR dither to RUN codes.
module ad_data_gen
  import ad_data_gen_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 6250,
  parameter logic [7:0]  MID_CODE   = DEF_MID_CODE,
  parameter int unsigned PIPE_LAT   = 3,
  parameter int unsigned STEP       = 1
) (
  input  logic       clk_four,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] hold_code,
  output logic [7:0] ad_data,
  output logic       settle_done
);
  state_e      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0]  pat, pat_n, core, core_n, raw;
  logic        dir_dn, dir_n, done_n, up_hit, dn_hit;
  logic [8:0]  up_sum, dn_dif;
  logic [7:0]  pipe [PIPE_LAT];
  // ninth bit catches overflow on the way up and borrow on the way down
  assign up_sum = {1'b0, pat} + 9'(STEP);
  assign dn_dif = {1'b0, pat} - 9'(STEP);
  assign up_hit = up_sum >= 9'd255;
  assign dn_hit = dn_dif[8] || dn_dif == 9'd0;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pat_n   = pat;
    dir_n   = 1'b0;
    done_n  = 1'b0;
    raw     = MID_CODE;
    if (!start) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      pat_n   = '0;
    end else begin
      case (state)
        ST_IDLE: state_n = ST_SETTLE;
        ST_SETTLE: begin
          cnt_n   = cnt + 16'd1;
          pat_n   = '0;
          state_n = cnt == 16'(SETTLE_CYC - 1) ? ST_RUN : ST_SETTLE;
        end
        default: begin
          done_n = 1'b1;
          raw    = mode == MODE_MID ? MID_CODE : mode == MODE_HOLD ? hold_code : pat;
          pat_n  = mode == MODE_RAMP ? up_sum[7:0] :
                   mode != MODE_TRI  ? pat :
                   dir_dn ? (dn_hit ? 8'd0 : dn_dif[7:0]) : (up_hit ? 8'd255 : up_sum[7:0]);
          dir_n  = mode == MODE_TRI && (dir_dn ? !dn_hit : up_hit);
        end
      endcase
    end
  end
`ifdef AD_DATA_GEN_NOISE_EN
  logic [1:0] dither;
  ad_data_gen_lfsr u_lfsr (.clk_four(clk_four), .sys_rst_n(sys_rst_n), .dither(dither));
  // dither saturates so full-scale codes never wrap
  assign core_n = !done_n ? raw :
                  (dither == 2'b01 && raw != 8'd255) ? raw + 8'd1 :
                  (dither == 2'b10 && raw != 8'd0)   ? raw - 8'd1 : raw;
`else
  assign core_n = raw;
`endif
  always_ff @(posedge clk_four or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pat         <= '0;
      dir_dn      <= 1'b0;
      core        <= MID_CODE;
      settle_done <= 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= MID_CODE;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pat         <= pat_n;
      dir_dn      <= dir_n;
      core        <= core_n;
      settle_done <= done_n;
      pipe[0]     <= core;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign ad_data = pipe[PIPE_LAT-1];
endmodule

// File: tb/tb_ad_data_gen.sv
// tb_ad_data_gen: randomized and directed check of ad_data_gen against a cycle-level reference model
module tb_ad_data_gen;
  localparam int S = 8;
  localparam int P = 3;
  logic       clk_four = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] hold_code = 8'd0;
  logic [7:0] ad_a, ad_b;
  logic       done_a, done_b;
  int n_chk = 0, n_fail = 0;

  ad_data_gen #(.SETTLE_CYC(S), .PIPE_LAT(P), .STEP(1)) dut_a (
    .clk_four(clk_four), .sys_rst_n(sys_rst_n), .start(start), .mode(mode),
    .hold_code(hold_code), .ad_data(ad_a), .settle_done(done_a));
  ad_data_gen #(.SETTLE_CYC(S), .PIPE_LAT(P), .STEP(100)) dut_b (
    .clk_four(clk_four), .sys_rst_n(sys_rst_n), .start(start), .mode(mode),
    .hold_code(hold_code), .ad_data(ad_b), .settle_done(done_b));

  always #5 clk_four = ~clk_four;

  // Reference: runs counts consecutive edges with start high; codes are RUN codes from
  // the (S+2)th such edge on. dl[k][0] is the latest core code, dl[k][P] what ad_data shows.
  int stp [2] = '{1, 100};
  int pat [2];
  int dl [2][P+1];
  int runs, exp_done;
  bit up [2];
  always @(posedge clk_four or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      runs = 0;
      exp_done = 0;
      for (int k = 0; k < 2; k++) begin
        pat[k] = 0;
        up[k] = 1'b1;
        for (int j = 0; j <= P; j++) dl[k][j] = 125;
      end
    end else begin
      runs = start ? runs + 1 : 0;
      exp_done = (runs >= S + 2) ? 1 : 0;
      for (int k = 0; k < 2; k++) begin
        for (int j = P; j > 0; j--) dl[k][j] = dl[k][j-1];
        if (exp_done == 0) begin
          dl[k][0] = 125;
          pat[k] = 0;
          up[k] = 1'b1;
        end else begin
          dl[k][0] = mode == 2'd0 ? 125 : mode == 2'd3 ? int'(hold_code) : pat[k];
          if (mode == 2'd1) pat[k] = (pat[k] + stp[k]) % 256;
          if (mode == 2'd2 && up[k]) begin
            pat[k] = pat[k] + stp[k];
            if (pat[k] >= 255) begin pat[k] = 255; up[k] = 1'b0; end
          end else if (mode == 2'd2) begin
            pat[k] = pat[k] - stp[k];
            if (pat[k] <= 0) begin pat[k] = 0; up[k] = 1'b1; end
          end
          if (mode != 2'd2) up[k] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_four);
    @(negedge clk_four);
`ifdef AD_DATA_GEN_NOISE_EN
    chk("ad_a_near", int'((int'(ad_a) - dl[0][P]) inside {[-1:1]}), 1);
    chk("ad_b_near", int'((int'(ad_b) - dl[1][P]) inside {[-1:1]}), 1);
`else
    chk("ad_a", int'(ad_a), dl[0][P]);
    chk("ad_b", int'(ad_b), dl[1][P]);
`endif
    chk("done_a", int'(done_a), exp_done);
    chk("done_b", int'(done_b), exp_done);
  endtask

  task automatic wait_val(input string tag, input bit b, input int val, input int lim);
    for (int i = 0; i < lim && int'(b ? ad_b : ad_a) != val; i++) cyc();
    chk(tag, int'(b ? ad_b : ad_a), val);
  endtask

  task automatic expect_seq(input string tag, input bit b, input int n, input int v [8]);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk(tag, int'(b ? ad_b : ad_a), v[i]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s [8];
    @(negedge clk_four);
    @(negedge clk_four);
    chk("rst_ad", int'(ad_a), 125);
    chk("rst_done", int'(done_a), 0);
    sys_rst_n = 1'b1;
    repeat (20) cyc();
`ifndef AD_DATA_GEN_NOISE_EN
    mode = 2'd1;
    start = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!done_a && n < 40);
    chk("done_lat", n - 1, 9);
    s = '{125, 125, 0, 1, 2, 3, 0, 0};
    expect_seq("ramp_start", 1'b0, 6, s);
    wait_val("wrap_find", 1'b0, 254, 300);
    s = '{255, 0, 1, 0, 0, 0, 0, 0};
    expect_seq("ramp_wrap", 1'b0, 3, s);
    mode = 2'd2;
    wait_val("peak_find", 1'b0, 253, 300);
    s = '{254, 255, 254, 253, 0, 0, 0, 0};
    expect_seq("tri_peak", 1'b0, 4, s);
    wait_val("trough_find", 1'b0, 2, 300);
    s = '{1, 0, 1, 2, 0, 0, 0, 0};
    expect_seq("tri_trough", 1'b0, 4, s);
    wait_val("tri100_find", 1'b1, 0, 20);
    s = '{100, 200, 255, 155, 55, 0, 100, 0};
    expect_seq("tri100", 1'b1, 7, s);
    mode = 2'd1;
    wait_val("stop_find", 1'b0, 40, 300);
    start = 1'b0;
    cyc();
    chk("stop_done", int'(done_a), 0);
    chk("stop_ad1", int'(ad_a), 41);
    s = '{42, 43, 125, 125, 0, 0, 0, 0};
    expect_seq("stop_mid", 1'b0, 4, s);
    start = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (ad_a != 8'd0 && n < 40);
    chk("restart_lat", n - 1, 12);
    s = '{1, 2, 3, 0, 0, 0, 0, 0};
    expect_seq("restart_ramp", 1'b0, 3, s);
`endif
    start = 1'b1;
    mode = 2'd3;
    hold_code = 8'd200;
    repeat (S + 6) cyc();
    s = '{200, 200, 200, 0, 0, 0, 0, 0};
    expect_seq("hold", 1'b0, 3, s);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_ad_a", int'(ad_a), 125);
    chk("arst_ad_b", int'(ad_b), 125);
    chk("arst_done", int'(done_a), 0);
    start = 1'b0;
    @(negedge clk_four);
    sys_rst_n = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 1500; i++) begin
      if (start ? $urandom_range(0, 59) == 0 : $urandom_range(0, 7) == 0) start = ~start;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      hold_code = 8'($urandom);
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ad_data_gen.md
# ad_data_gen

Synthesizable stand-in for the external 8-bit ADC feeding the digital voltmeter path. Runs on `clk_four`, the ADC sample clock, and drives `ad_data` the way the converter does. After start it holds mid-scale so the downstream median/zero-calibration logic can settle, then produces selectable test waveforms through a fixed pipeline delay matching the converter's output latency. It is used in the bench and in on-board loopback builds in place of the physical ADC.

## Interface
Parameters:
- `SETTLE_CYC`, 6250: cycles of mid-scale hold after start (500 us at 12.5 MHz); legal range 1..65535.
- `MID_CODE`, 8'd125: mid-scale code, corresponding to 0 V.
- `PIPE_LAT`, 3: output pipeline depth in cycles; legal range 1..8.
- `STEP`, 1: increment per cycle for ramp and triangle; legal range 1..255.

Ports:
- `clk_four`  in  1: ADC sample clock; all logic is rising-edge.
- `sys_rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: level enable. 1 runs the generator; 0 returns it to idle.
- `mode`  in  2: waveform select. 00 = mid, 01 = ramp, 10 = triangle, 11 = hold.
- `hold_code`  in  8: constant output code used when `mode` is 11.
- `ad_data`  out  8: sample code, registered.
- `settle_done`  out  1: high while in RUN, registered.

## Operation
- The FSM has three states: IDLE, SETTLE and RUN.
  - IDLE: the core code is MID_CODE and the settle counter is 0. If `start` is 1, go to SETTLE.
  - SETTLE: the core code is MID_CODE and the counter increments each cycle. When the counter reaches SETTLE_CYC-1, go to RUN.
  - RUN: the core code follows `mode`.
- Leaving any state: if `start` is 0 in SETTLE or RUN, the next state is IDLE. This clears the counter, the pattern register and the direction bit. A restart always repeats the full SETTLE.
- Pattern register: the 8-bit pattern register resets to 0 on entry to RUN.
- Ramp (01): code, code+STEP, and so on, modulo 256. Example with STEP=1: 255 is followed by 0.
- Triangle (10):
  - Counts up by STEP, then down by STEP.
  - The next value is clamped to 255 or 0, and the direction flips when a clamp is reached.
  - Each endpoint appears exactly once per turn, e.g. 254, 255, 254 and 1, 0, 1.
- Direction bit: forced to "up" on RUN entry and whenever `mode` is not 10.
- Mid (00): code is MID_CODE. Hold (11): code is `hold_code`, sampled every cycle. In both modes the pattern register keeps its value.
- Mode change in RUN: takes effect on the next core code. Ramp and triangle continue from the current pattern register value.
- Output pipeline: `ad_data` is the core code delayed through a PIPE_LAT-stage shift register. All stages reset to MID_CODE.
- `settle_done` goes high in the same cycle the core first emits a RUN code. It is not delayed by the pipeline.

## Timing
- Reset (asynchronous):
  - `ad_data` = MID_CODE, `settle_done` = 0, state = IDLE.
  - All pipeline stages = MID_CODE, counter = 0, pattern register = 0.
- Start sequence: `start` is sampled at edge E0.
  - SETTLE spans edges E1 through E(SETTLE_CYC).
  - The first RUN core code is valid after edge E(SETTLE_CYC+1).
  - The matching `ad_data` is valid PIPE_LAT edges later.
- Stop: when `start` falls, the core returns to MID_CODE after the next edge. `ad_data` reaches MID_CODE PIPE_LAT edges after that.
- Reset asserted mid-operation: all outputs and pipeline stages go to their reset values immediately, with no clock edge needed.

## Configuration
- `AD_DATA_GEN_NOISE_EN` defined:
  - Adds a 16-bit Fibonacci LFSR (taps 16, 14, 13, 11; seed 16'hACE1 on reset) that advances every cycle in every state.
  - In RUN only, a dither is added to the core code before the pipeline, selected by LFSR[1:0]: 00 → 0, 01 → +1, 10 → −1, 11 → 0.
  - The dithered result saturates to 0..255.
  - No dither is applied in IDLE or SETTLE.
- Macro not defined: no LFSR is built and the output is exactly the waveform described in Operation.

## Structure
- Package `ad_data_gen_pkg`:
  - mode encodings (MODE_MID, MODE_RAMP, MODE_TRI, MODE_HOLD);
  - FSM state encoding;
  - default MID_CODE;
  - LFSR seed and tap constants.
- Sub-module `ad_data_gen_lfsr` (16-bit LFSR with a 2-bit dither output). It is instantiated only under `AD_DATA_GEN_NOISE_EN`.

## Test plan
Unless stated otherwise, tests use SETTLE_CYC=8, PIPE_LAT=3, STEP=1 and the noise macro undefined.
1. Reset with `start`=0: `ad_data`=125 and `settle_done`=0, held for 20 cycles.
2. Ramp start: `start`=1, `mode`=01.
   - `settle_done` rises 9 edges after `start` is sampled.
   - `ad_data` sequence is 125 ×(through settle and pipe fill), then 0, 1, 2, 3; the 0 appears 3 edges after `settle_done` rises.
3. Ramp wrap: run 260 cycles. `ad_data` shows 254, 255, 0, 1 with no gap.
4. Triangle (`mode`=10):
   - The peak reads 253, 254, 255, 254, 253 and the trough reads 2, 1, 0, 1, 2.
   - With STEP=100 the sequence is 0, 100, 200, 255, 155, 55, 0, 100.
5. Stop and restart:
   - Drop `start` mid-ramp at code 40: `ad_data` returns to 125 within 4 edges and `settle_done` falls after 1 edge.
   - Re-raise `start`: 8 further settle cycles at 125 occur before the ramp restarts from 0.
6. Hold and async reset:
   - `mode`=11 with `hold_code`=200 gives a constant 200.
   - Asserting `sys_rst_n` low between clock edges forces `ad_data`=125 and `settle_done`=0 immediately.
   - With the macro defined, every RUN sample stays within ±1 of its undithered value, and 0/255 never wrap.
